rca_serial_controller: RTL and testbench

Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one internal 4-bit ripple-carry adder slice (RCA4 built from full_adder cells) over WIDTH/4 nibbles, least significant first. A registered carry links consecutive slices. The block sits between a requester issuing start/op/operand commands and the shared nibble datapath. It trades latency for area versus a full-width combinational adder.

---
 rtl/rca_serial_controller_if.sv | 33 +++
 rtl/rca_serial_controller.sv | 136 +++++++++++++
 tb/tb_rca_serial_controller.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/rca_serial_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : rca_serial_controller_if
//  Description : Command/result bundle between a requester and the
//                nibble-serial add/subtract sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface rca_serial_controller_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    // Requester side: issues commands, observes status and results
    modport master (
        output start, op_sub, a, b,
        input  busy, done, result, cout, ovf
    );

    // Sequencer side: accepts commands, produces status and results
    modport slave (
        input  start, op_sub, a, b,
        output busy, done, result, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/rca_serial_controller.sv
`default_nettype none
// ============================================================================
//  Module      : rca_serial_controller
//  Description : WIDTH-bit add/subtract performed one nibble per cycle on a
//                single 4-bit ripple-carry slice, LSB nibble first, with a
//                registered carry linking consecutive slices.
//                WIDTH must be a multiple of 4 and at least 8.
//  Revision    : 1.0  initial release
// ============================================================================
module rca_serial_controller #(
    parameter int WIDTH = 16
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    rca_serial_controller_if.slave       bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDX_W  = $clog2(NSLICE);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_result;
    logic [IDX_W-1:0]   r_idx;
    logic               r_cy;
    logic               r_cout;
    logic               r_ovf;

    logic               w_accept;
    logic               w_busy;
    logic               w_done;
    logic               w_last;
    logic [3:0]         w_sa;
    logic [3:0]         w_sb;
    logic [3:0]         w_sum;
    logic [4:0]         w_c;

    // Operand nibbles for the slice currently being processed
    assign w_sa   = r_a[4*r_idx +: 4];
    assign w_sb   = r_b[4*r_idx +: 4];
    assign w_c[0] = r_cy;
    assign w_last = (r_idx == c_LAST_IDX);

    // Shared 4-bit ripple-carry slice built from four full-adder cells
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign w_sum[i]  = w_sa[i] ^ w_sb[i] ^ w_c[i];
        assign w_c[i+1]  = (w_sa[i] & w_sb[i]) | (w_c[i] & (w_sa[i] ^ w_sb[i]));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status decode; a start is taken whenever not busy
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture on accept; one nibble of result per RUN cycle.
    // Subtraction is A + ~B + 1, the +1 entering as the initial carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_cy     <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a      <= bus.a;
            r_b      <= bus.op_sub ? ~bus.b : bus.b;
            r_cy     <= bus.op_sub;
            r_idx    <= '0;
            r_result <= '0;
        end else if (r_state == S_RUN) begin
            r_result[4*r_idx +: 4] <= w_sum;
            r_cy                   <= w_c[4];
            r_idx                  <= r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_c[4];
                r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[3] != r_a[WIDTH-1]);
            end
        end
    end

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.result = r_result;
    assign bus.cout   = r_cout;
    assign bus.ovf    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_rca_serial_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rca_serial_controller
//  Description : Directed self-checking bench for rca_serial_controller
//                (WIDTH=16) with an expected-result queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rca_serial_controller;
    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   t_start     = 0;
    exp_t sb_q[$];

    rca_serial_controller_if #(.WIDTH(WIDTH)) bus ();

    rca_serial_controller #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic computed from the operands, not from the design
    function automatic exp_t model(input logic sub, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        logic [WIDTH:0] full;
        if (sub) begin
            full = {1'b0, a} + {1'b0, ~b} + 17'd1;
            e.v  = (a[WIDTH-1] != b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            e.v  = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        end
        e.r = full[WIDTH-1:0];
        e.c = full[WIDTH];
        return e;
    endfunction

    // Present a command for one edge; optionally record its expected result
    task automatic issue(input logic sub, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit push);
        bus.start  = 1'b1;
        bus.op_sub = sub;
        bus.a      = a;
        bus.b      = b;
        if (push) sb_q.push_back(model(sub, a, b));
        tick();
        t_start    = cyc;
        bus.start  = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
    endtask

    // Wait (bounded) for done, checking busy on the way, then score the result
    task automatic wait_done(input string tag);
        bit   seen = 0;
        exp_t e;
        for (int k = 0; k < 20; k++) begin
            if (bus.done === 1'b1) begin
                seen = 1;
                break;
            end
            check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            tick();
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_latency"}, 32'(cyc - t_start), 32'(NSLICE));
            check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
            if (sb_q.size() == 0) begin
                check({tag, "_queue_nonempty"}, 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                check({tag, "_result"}, 32'(bus.result), 32'(e.r));
                check({tag, "_cout"},   32'(bus.cout),   32'(e.c));
                check({tag, "_ovf"},    32'(bus.ovf),    32'(e.v));
            end
        end
    endtask

    // Check that the block sits quiet for n cycles
    task automatic expect_quiet(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            check({tag, "_no_done"}, 32'(bus.done), 32'd0);
            check({tag, "_no_busy"}, 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.op_sub = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        rst        = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_busy",   32'(bus.busy),   32'd0);
        check("rst_done",   32'(bus.done),   32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_cout",   32'(bus.cout),   32'd0);
        check("rst_ovf",    32'(bus.ovf),    32'd0);

        // Plain additions and subtractions with carry / overflow corners
        issue(1'b0, 16'h1234, 16'h4321, 1'b1); wait_done("add_5555");
        expect_quiet("after_add", 1);
        check("hold_result", 32'(bus.result), 32'h5555);
        issue(1'b0, 16'hFFFF, 16'h0001, 1'b1); wait_done("add_wrap");
        issue(1'b0, 16'h7FFF, 16'h0001, 1'b1); wait_done("add_ovf");
        issue(1'b1, 16'h0005, 16'h0007, 1'b1); wait_done("sub_borrow");
        issue(1'b1, 16'h8000, 16'h0001, 1'b1); wait_done("sub_ovf");
        issue(1'b1, 16'h1234, 16'h1234, 1'b1); wait_done("sub_zero");

        // Start while busy is ignored
        issue(1'b0, 16'h1111, 16'h2222, 1'b1);
        tick();
        bus.start = 1'b1; bus.op_sub = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h5555;
        tick();
        bus.start = 1'b0;
        wait_done("ignored_start");
        expect_quiet("single_done", 3);
        check("ignored_hold", 32'(bus.result), 32'h3333);

        // Back-to-back start in the DONE cycle
        issue(1'b0, 16'hABCD, 16'h1111, 1'b1);
        wait_done("b2b_first");
        issue(1'b0, 16'h0F0F, 16'h00F1, 1'b1);
        wait_done("b2b_second");

        // Reset in the second RUN cycle aborts without a done pulse
        issue(1'b0, 16'h1234, 16'h1111, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy",   32'(bus.busy),   32'd0);
        check("abort_done",   32'(bus.done),   32'd0);
        check("abort_result", 32'(bus.result), 32'd0);
        check("abort_cout",   32'(bus.cout),   32'd0);
        check("abort_ovf",    32'(bus.ovf),    32'd0);
        expect_quiet("abort", 6);
        issue(1'b0, 16'h0001, 16'h0002, 1'b1); wait_done("after_abort");

        check("queue_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
